fp16_result_packer: RTL and testbench

// - Output end of the half-precision (binary16) adder datapath: the operand bank orders inputs by

---
 rtl/fp16_pkg.sv | 11 +
 rtl/fp16_round_pack.sv | 17 +
 rtl/fp16_result_packer.sv | 76 +++++++
 tb/tb_fp16_result_packer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 constants and the result packer state encoding
package fp16_pkg;
    localparam int EXP_W = 5;
    localparam int FRAC_W = 10;
    localparam int MANT_W = FRAC_W + 4;
    localparam int BIAS = 15;
    localparam int EXP_MAX = 31;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: round-to-nearest-even and pack a normalised mantissa into binary16
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_W:0]    exp,
    input  logic [MANT_W-1:0] mant,
    output logic [15:0]       result
);
    logic round_up;
    logic [15:0] base;
    assign round_up = mant[1] & (mant[0] | mant[2]);
    // A rounding carry out of the fraction bumps the exponent field directly
    assign base = {sign, mant[FRAC_W+2] ? exp[EXP_W-1:0] : {EXP_W{1'b0}}, mant[FRAC_W+1:2]};
    assign result = (exp >= (EXP_W+1)'(EXP_MAX)) ? (FP16_POS_INF | {sign, 15'd0}) :
                    (mant == '0) ? FP16_ZERO : base + 16'(round_up);
endmodule

// File: rtl/fp16_result_packer.sv
// fp16_result_packer: normalise an aligned mantissa sum one bit per cycle, then round and pack
module fp16_result_packer
    import fp16_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       result
);
    state_t state, state_n;
    logic sign_q;
    logic [EXP_W:0] exp_q, exp_n;
    logic [MANT_W-1:0] mant_q, mant_n;
    logic [15:0] result_q, packed_result;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign result = result_q;

    fp16_round_pack u_round_pack (
        .sign   (sign_q),
        .exp    (exp_q),
        .mant   (mant_q),
        .result (packed_result)
    );

    always_comb begin
        state_n = state;
        exp_n = exp_q;
        mant_n = mant_q;
        case (state)
            IDLE: if (in_valid) begin
                state_n = NORM;
                exp_n = {1'b0, in_exp};
                mant_n = in_mant;
            end
            NORM: if (mant_q[MANT_W-1]) begin
                mant_n = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                exp_n = exp_q + 1'b1;
            end else if (mant_q == '0) begin
                state_n = ROUND;
            end else if (!mant_q[MANT_W-2] && exp_q > (EXP_W+1)'(1)) begin
                // Left shifts stop at exp 1, leaving the value in the subnormal range
                mant_n = {mant_q[MANT_W-2:0], 1'b0};
                exp_n = exp_q - 1'b1;
            end else begin
                state_n = ROUND;
            end
            ROUND: state_n = DONE;
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sign_q <= 1'b0;
            exp_q <= '0;
            mant_q <= '0;
            result_q <= FP16_ZERO;
        end else begin
            state <= state_n;
            exp_q <= exp_n;
            mant_q <= mant_n;
            if (state == IDLE && in_valid) sign_q <= in_sign;
            if (state == ROUND) result_q <= packed_result;
        end
    end
endmodule

// File: tb/tb_fp16_result_packer.sv
// tb_fp16_result_packer: directed and random checks against an arithmetic binary16 model
module tb_fp16_result_packer;
    logic clock = 0;
    logic reset = 1;
    logic in_valid = 0;
    logic in_ready;
    logic in_sign = 0;
    logic [4:0] in_exp = 5'd1;
    logic [13:0] in_mant = '0;
    logic out_valid;
    logic out_ready = 0;
    logic [15:0] result;
    int total = 0;
    int passed = 0;

    fp16_result_packer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Normalisation shift count comes from the leading-one position, rounding from the remainder
    function automatic void model(input logic s, input int e, input int m,
                                  output logic [15:0] r, output int lat);
        int k, keep, rem, up, mag;
        if (m == 0) begin
            r = 16'h0000;
            lat = 2;
            return;
        end
        if (m >= 8192) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            lat = 3;
        end else begin
            k = 12 - ($clog2(m + 1) - 1);
            if (k > e - 1) k = e - 1;
            m = m << k;
            e = e - k;
            lat = 2 + k;
        end
        if (e >= 31) begin
            r = {s, 15'h7C00};
            return;
        end
        keep = m >> 2;
        rem = m & 3;
        up = (rem > 2 || (rem == 2 && keep % 2 == 1)) ? 1 : 0;
        mag = (keep >= 1024) ? e * 1024 + keep - 1024 + up : keep + up;
        r = {s, 15'(mag)};
    endfunction

    task automatic run(input string tag, input logic s, input logic [4:0] e,
                       input logic [13:0] m, input logic [15:0] exp_r, input int exp_lat);
        int cyc = 0;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        in_valid = 1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        while (!out_valid && cyc < 30) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, 32'(result), 32'(exp_r));
        out_ready = 1;
        step();
        out_ready = 0;
        check({tag, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] r;
        logic [13:0] m;
        logic [4:0] e;
        logic s;
        int lat, cyc;
        step();
        step();
        reset = 0;
        check("reset", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});

        run("carry", 0, 5'd15, 14'b10_0000000000_00, 16'h4000, 3);
        run("cancel", 0, 5'd15, 14'b00_0000000001_00, 16'h1400, 12);
        run("rne_up", 0, 5'd15, {2'b01, 10'h3FF, 2'b10}, 16'h4000, 2);
        run("rne_tie_even", 0, 5'd15, {2'b01, 10'h000, 2'b10}, 16'h3C00, 2);
        run("rne_tie_odd", 1, 5'd15, {2'b01, 10'h001, 2'b10}, 16'hBC02, 2);
        run("overflow", 1, 5'd30, 14'b10_0000000000_00, 16'hFC00, 3);
        run("subnormal", 0, 5'd1, 14'b00_0100000000_00, 16'h0100, 2);
        run("sub_to_normal", 0, 5'd1, {2'b00, 10'h3FF, 2'b11}, 16'h0400, 2);
        run("max_to_inf", 0, 5'd30, {2'b01, 10'h3FF, 2'b11}, 16'h7C00, 2);
        run("zero", 1, 5'd20, 14'd0, 16'h0000, 2);

        // Consumer stall: output must hold while new requests are ignored
        in_sign = 0;
        in_exp = 5'd15;
        in_mant = {2'b01, 10'h155, 2'b00};
        in_valid = 1;
        step();
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            step();
            cyc++;
        end
        r = result;
        check("stall result", 32'(r), 32'h3D55);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_sign = 1;
            in_exp = 5'($urandom_range(1, 30));
            in_mant = 14'($urandom);
            step();
            check("stall hold", {14'd0, out_valid, in_ready, result}, {14'd0, 1'b1, 1'b0, r});
        end
        in_valid = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        check("stall release", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset in the middle of a long normalisation
        in_sign = 1;
        in_exp = 5'd15;
        in_mant = 14'b00_0000000001_00;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        step();
        reset = 1;
        step();
        check("reset mid norm", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});
        reset = 0;
        step();
        check("post reset idle", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});
        run("after reset", 0, 5'd15, 14'b10_0000000000_00, 16'h4000, 3);

        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            e = 5'($urandom_range(1, 30));
            m = 14'($urandom) >> $urandom_range(0, 13);
            model(s, int'(e), int'(m), r, lat);
            run($sformatf("rand%0d", i), s, e, m, r, lat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
